gumnut_io_responder: RTL and testbench

//  Peripheral-side responder for the Gumnut core I/O port bus and interrupt handshake.

---
 rtl/gumnut_io_responder.sv | 155 +++++++++++++++
 tb/tb_gumnut_io_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gumnut_io_responder.sv
// Gumnut I/O port responder: GPIO out/in, reloadable prescaled timer and interrupt handshake.
// Optional CTRL.EDGE interrupt source on gpio_i[0] is built when GUMNUT_IO_EDGE_IRQ_EN is defined.
module gumnut_io_responder #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int unsigned PRESCALE  = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       port_cyc_i,
    input  logic       port_stb_i,
    input  logic       port_we_i,
    input  logic [7:0] port_adr_i,
    input  logic [7:0] port_dat_i,
    output logic [7:0] port_dat_o,
    output logic       port_ack_o,
    output logic       int_req_o,
    input  logic       int_ack_i,
    input  logic [7:0] gpio_i,
    output logic [7:0] gpio_o
);
    localparam int unsigned PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PsLast = PW'(PRESCALE - 1);

    typedef enum logic {StIdle, StAck} state_t;

    state_t      state_q, state_d;
    logic        start;
    logic        hit;
    logic [1:0]  offset;
    logic        wr_out, wr_reload, wr_ctrl;
    logic [7:0]  rd_data;
    logic [7:0]  dat_q;
    logic [7:0]  out_q;
    logic [7:0]  gpio_meta_q, gpio_sync_q;
    logic [7:0]  reload_q, count_q;
    logic [PW-1:0] presc_q;
    logic        ten_q, ien_q, tflag_q;
    logic        tick;
    logic        edge_flag;
    logic        int_req_q;

    assign hit    = (port_adr_i[7:2] == BASE_ADDR[7:2]);
    assign offset = port_adr_i[1:0];

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (port_cyc_i && port_stb_i && hit) begin
                    state_d = StAck;
                    start   = 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    assign wr_out    = start && port_we_i && (offset == 2'd0);
    assign wr_reload = start && port_we_i && (offset == 2'd2);
    assign wr_ctrl   = start && port_we_i && (offset == 2'd3);

    always_comb begin
        rd_data = 8'h00;
        unique case (offset)
            2'd0: rd_data = out_q;
            2'd1: rd_data = gpio_sync_q;
            2'd2: rd_data = reload_q;
            2'd3: rd_data = {tflag_q, edge_flag, 4'b0000, ien_q, ten_q};
            default: rd_data = 8'h00;
        endcase
    end

    // Read data is held only for the single ack cycle, zero otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_q       <= 8'h00;
            out_q       <= 8'h00;
            gpio_meta_q <= 8'h00;
            gpio_sync_q <= 8'h00;
            ten_q       <= 1'b0;
            ien_q       <= 1'b0;
        end else begin
            dat_q       <= (start && !port_we_i) ? rd_data : 8'h00;
            gpio_meta_q <= gpio_i;
            gpio_sync_q <= gpio_meta_q;
            if (wr_out) out_q <= port_dat_i;
            if (wr_ctrl) begin
                ten_q <= port_dat_i[0];
                ien_q <= port_dat_i[1];
            end
        end
    end

    assign tick = ten_q && (presc_q == PsLast) && !wr_reload;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reload_q <= 8'hFF;
            count_q  <= 8'hFF;
            presc_q  <= '0;
            tflag_q  <= 1'b0;
        end else begin
            if (wr_reload) begin
                reload_q <= port_dat_i;
                count_q  <= port_dat_i;
                presc_q  <= '0;
            end else if (ten_q) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick) count_q <= (count_q == 8'h00) ? reload_q : count_q - 8'h01;
            end else begin
                presc_q <= '0;
            end
            // Hardware set takes priority over a coincident write-1-to-clear.
            tflag_q <= (tick && (count_q == 8'h00)) || (tflag_q && !(wr_ctrl && port_dat_i[7]));
        end
    end

`ifdef GUMNUT_IO_EDGE_IRQ_EN
    logic sync0_prev_q, edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync0_prev_q <= 1'b0;
            edge_q       <= 1'b0;
        end else begin
            sync0_prev_q <= gpio_sync_q[0];
            edge_q <= (gpio_sync_q[0] && !sync0_prev_q) ||
                      (edge_q && !(wr_ctrl && port_dat_i[6]));
        end
    end

    assign edge_flag = edge_q;
`else
    assign edge_flag = 1'b0;
`endif

    // int_ack_i masks the request for one cycle; a still-pending level source reasserts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) int_req_q <= 1'b0;
        else         int_req_q <= ien_q && (tflag_q || edge_flag) && !int_ack_i;
    end

    assign port_ack_o = (state_q == StAck);
    assign port_dat_o = dat_q;
    assign int_req_o  = int_req_q;
    assign gpio_o     = out_q;

endmodule

// File: tb/tb_gumnut_io_responder.sv
// Directed self-checking bench for gumnut_io_responder (BASE_ADDR=8'h10, PRESCALE=4).
module tb_gumnut_io_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [7:0] adr = 8'h00, wdat = 8'h00;
    logic [7:0] rdat;
    logic       ack, int_req;
    logic       int_ack = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc_cnt = 0;
    int unsigned c0, c1, c2;

    localparam logic [7:0] Base = 8'h10;
`ifdef GUMNUT_IO_EDGE_IRQ_EN
    localparam logic [7:0] EdgeReq  = 8'h01;
    localparam logic [7:0] EdgeCtrl = 8'h42;
`else
    localparam logic [7:0] EdgeReq  = 8'h00;
    localparam logic [7:0] EdgeCtrl = 8'h02;
`endif

    gumnut_io_responder #(.BASE_ADDR(8'h10), .PRESCALE(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .port_cyc_i (cyc),
        .port_stb_i (stb),
        .port_we_i  (we),
        .port_adr_i (adr),
        .port_dat_i (wdat),
        .port_dat_o (rdat),
        .port_ack_o (ack),
        .int_req_o  (int_req),
        .int_ack_i  (int_ack),
        .gpio_i     (gpio_in),
        .gpio_o     (gpio_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(posedge clk); #1;
        check("wr_ack", {7'd0, ack}, 8'h01);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("wr_ack_drop", {7'd0, ack}, 8'h00);
    endtask

    task automatic bus_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk); #1;
        check("rd_ack", {7'd0, ack}, 8'h01);
        check(tag, rdat, exp);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("rd_ack_drop", {7'd0, ack}, 8'h00);
        check("rd_dat_idle", rdat, 8'h00);
    endtask

    initial begin
        #12;
        check("rst_ack", {7'd0, ack}, 8'h00);
        check("rst_dat", rdat, 8'h00);
        check("rst_int", {7'd0, int_req}, 8'h00);
        check("rst_gpio", gpio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        bus_read("ctrl_reset", Base + 8'd3, 8'h00);
        bus_read("reload_reset", Base + 8'd2, 8'hFF);
        bus_write(Base, 8'hA5);
        check("gpio_out_a5", gpio_out, 8'hA5);
        bus_read("out_rb", Base, 8'hA5);

        // Address outside the window never acks.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h20; wdat = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("miss_no_ack", {7'd0, ack}, 8'h00);
        end
        // Strobe without cyc is ignored.
        cyc = 1'b0; adr = Base; wdat = 8'hFF;
        @(posedge clk); #1;
        check("nocyc_no_ack", {7'd0, ack}, 8'h00);
        check("nocyc_gpio", gpio_out, 8'hA5);
        stb = 1'b0; we = 1'b0;

        // Held strobe acks every other cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = Base;
        @(posedge clk); #1; check("b2b_ack1", {7'd0, ack}, 8'h01);
        @(posedge clk); #1; check("b2b_gap", {7'd0, ack}, 8'h00);
        @(posedge clk); #1; check("b2b_ack2", {7'd0, ack}, 8'h01);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1; check("b2b_end", {7'd0, ack}, 8'h00);

        // Input synchroniser: same-edge read still sees the old value.
        @(negedge clk);
        gpio_in = 8'h3C; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 8'd1;
        @(posedge clk); #1;
        check("in_not_yet", rdat, 8'h00);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        bus_read("in_synced", Base + 8'd1, 8'h3C);
        bus_write(Base + 8'd1, 8'hFF);
        bus_read("in_ro", Base + 8'd1, 8'h3C);

        // Timer: 3 ticks of 4 clocks to flag, request registered one clock later.
        bus_write(Base + 8'd2, 8'h02);
        bus_write(Base + 8'd3, 8'h03);
        c0 = cyc_cnt - 1;
        for (int i = 0; i < 40 && !int_req; i++) begin
            @(posedge clk); #1;
        end
        c1 = cyc_cnt;
        check("irq_first", {7'd0, int_req}, 8'h01);
        check("irq_latency", 8'(c1 - c0), 8'd13);

        int_ack = 1'b1;
        @(posedge clk); #1;
        check("irq_masked", {7'd0, int_req}, 8'h00);
        int_ack = 1'b0;
        @(posedge clk); #1;
        check("irq_reassert", {7'd0, int_req}, 8'h01);

        bus_write(Base + 8'd3, 8'h83);
        check("irq_cleared", {7'd0, int_req}, 8'h00);
        bus_read("ctrl_w1c", Base + 8'd3, 8'h03);
        for (int i = 0; i < 40 && !int_req; i++) begin
            @(posedge clk); #1;
        end
        c2 = cyc_cnt;
        check("irq_second", {7'd0, int_req}, 8'h01);
        check("irq_period", 8'(c2 - c1), 8'd12);

        // IEN=0: flag still sets but no request.
        bus_write(Base + 8'd3, 8'h81);
        repeat (20) @(posedge clk);
        #1;
        check("ien_off_int", {7'd0, int_req}, 8'h00);
        bus_read("ctrl_flag_noien", Base + 8'd3, 8'h81);

        bus_write(Base + 8'd3, 8'h00);
        bus_write(Base + 8'd3, 8'hC2);
        check("pre_edge_int", {7'd0, int_req}, 8'h00);
        @(negedge clk);
        gpio_in = 8'h3D;
        repeat (4) @(posedge clk);
        #1;
        check("edge_int", {7'd0, int_req}, EdgeReq);
        bus_read("edge_ctrl", Base + 8'd3, EdgeCtrl);

        // Async reset during a strobed write: no partial write, ack dropped.
        gpio_in = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = Base; wdat = 8'h5A;
        #2 rst_n = 1'b0;
        #1;
        check("arst_gpio_now", gpio_out, 8'h00);
        @(posedge clk); #1;
        check("arst_gpio", gpio_out, 8'h00);
        check("arst_ack", {7'd0, ack}, 8'h00);
        check("arst_int", {7'd0, int_req}, 8'h00);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read("arst_out", Base, 8'h00);
        bus_read("arst_ctrl", Base + 8'd3, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
